// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on a shared oversample tick; `define UART_RX_SYNC_EN adds a 2-flop rx synchronizer.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic rx_s, half, last;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) sync <= rst ? 2'b11 : {sync[0], rx};
  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif
  assign half = cnt == HALF;
  assign last = cnt == LAST;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (tick)
      case (state)
        IDLE:    state_n = rx_s ? IDLE : START;
        START:   state_n = half ? (rx_s ? IDLE : DATA) : START;
        DATA:    state_n = (last && bit_cnt == 3'd7) ? STOP : DATA;
        STOP:    state_n = last ? IDLE : STOP;
        default: state_n = IDLE;
      endcase
  end
  always_comb o_rx_busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      if (tick)
        case (state)
          IDLE: cnt <= '0;
          START: begin
            cnt     <= half ? '0 : cnt + 1'b1;
            bit_cnt <= (half && !rx_s) ? 3'd0 : bit_cnt;
          end
          DATA: begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              shift   <= {rx_s, shift[7:1]};
              bit_cnt <= (bit_cnt == 3'd7) ? bit_cnt : bit_cnt + 3'd1;
            end
          end
          STOP: begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              o_rx_data   <= shift;
              o_frame_err <= ~rx_s;
              o_rx_done   <= 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
    end
endmodule
